// File: rtl/cfr_access_arb_pkg.sv
// rtl/cfr_access_arb_pkg.sv - shared CFR widths, arbiter state type and CFR address map
package aimc_lib;

    localparam int CFR_ADDR_WIDTH = 12;
    localparam int DATA_WIDTH     = 32;
    localparam int MASK_WIDTH     = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } cfr_arb_state_t;

    // The one place the mapped CFR addresses are listed.
    function automatic bit cfr_addr_legal(input logic [CFR_ADDR_WIDTH-1:0] addr);
        case (addr)
            12'h000,
            12'h008, 12'h009, 12'h00A, 12'h00B, 12'h00C, 12'h00D,
            12'h010,
            12'h018,
            12'h020: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cfr_access_arb_if.sv
// rtl/cfr_access_arb_if.sv - requester-side request/response bundle of the CFR arbiter
interface cfr_access_arb_if
    import aimc_lib::*;
#(
    parameter int NUM_REQ = 2
);

    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_REQ-1:0]                req_wr;
    logic [NUM_REQ*CFR_ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*MASK_WIDTH-1:0]     req_mask;
    logic [NUM_REQ*DATA_WIDTH-1:0]     req_din;
    logic [NUM_REQ-1:0]                rsp_valid;
    logic [NUM_REQ-1:0]                rsp_ready;
    logic [DATA_WIDTH-1:0]             rsp_data;
    logic                              rsp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_mask, req_din, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_mask, req_din, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/cfr_access_arb_rr_arbiter.sv
// rtl/cfr_access_arb_rr_arbiter.sv - round-robin grant starting at a pointer
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    input  logic                       en,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Scan indices rr_ptr, rr_ptr+1, ... with wrap; the first requesting one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        sum       = '0;
        cand      = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                grant     = NUM_REQ'(1) << cand;
                grant_idx = cand;
            end
        end
    end

endmodule

// File: rtl/cfr_access_arb.sv
// rtl/cfr_access_arb.sv - round-robin sharing of the single CFR access port
module cfr_access_arb
    import aimc_lib::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    cfr_access_arb_if.slave           req_if,
    output logic                      cfr_we,
    output logic                      cfr_re,
    output logic [CFR_ADDR_WIDTH-1:0] cfr_addr,
    output logic [MASK_WIDTH-1:0]     cfr_mask,
    output logic [DATA_WIDTH-1:0]     cfr_din,
    input  logic [DATA_WIDTH-1:0]     cfr_dout
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    cfr_arb_state_t state, state_nxt;

    logic [IDX_W-1:0]          rr_ptr;
    logic [IDX_W-1:0]          own_idx;
    logic [IDX_W-1:0]          grant_idx;
    logic [NUM_REQ-1:0]        grant;
    logic                      wr_q;
    logic [DATA_WIDTH-1:0]     rsp_data_q;
    logic                      rsp_err_q;

    logic                      sel_wr;
    logic [CFR_ADDR_WIDTH-1:0] sel_addr;
    logic [MASK_WIDTH-1:0]     sel_mask;
    logic [DATA_WIDTH-1:0]     sel_din;
    logic                      sel_legal;
    logic                      accept;
    logic                      rsp_done;

    // Arbitration only runs in IDLE, so the grant doubles as the one-hot ready.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req       (req_if.req_valid),
        .rr_ptr    (rr_ptr),
        .en        (state == IDLE),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Pick out the granted requester's payload and classify its address.
    always_comb begin
        sel_wr    = req_if.req_wr[grant_idx];
        sel_addr  = req_if.req_addr[grant_idx*CFR_ADDR_WIDTH +: CFR_ADDR_WIDTH];
        sel_mask  = req_if.req_mask[grant_idx*MASK_WIDTH +: MASK_WIDTH];
        sel_din   = req_if.req_din[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        sel_legal = cfr_addr_legal(sel_addr);
        accept    = (state == IDLE) && (|grant);
        rsp_done  = (state == RESP) && req_if.rsp_ready[own_idx];
    end

    // Ready is masked by reset so nothing looks acceptable while held in reset.
    assign req_if.req_ready = grant & {NUM_REQ{rst_n}};
    assign req_if.rsp_data  = rsp_data_q;
    assign req_if.rsp_err   = rsp_err_q;

    // Response valid goes only to the owner of the current transaction.
    always_comb begin
        req_if.rsp_valid = '0;
        if (state == RESP) begin
            req_if.rsp_valid[own_idx] = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: illegal addresses skip the CFR entirely, reads take an extra wait cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = sel_legal ? ISSUE : RESP;
                end
            end
            ISSUE:   state_nxt = wr_q ? RESP : WAIT;
            WAIT:    state_nxt = RESP;
            RESP: begin
                if (rsp_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Transaction capture, registered CFR strobes/buses and response data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            own_idx    <= '0;
            wr_q       <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            cfr_we     <= 1'b0;
            cfr_re     <= 1'b0;
            cfr_addr   <= '0;
            cfr_mask   <= '0;
            cfr_din    <= '0;
        end else begin
            cfr_we   <= 1'b0;
            cfr_re   <= 1'b0;
            cfr_addr <= '0;
            cfr_mask <= '0;
            cfr_din  <= '0;
            if (accept) begin
                own_idx    <= grant_idx;
                wr_q       <= sel_wr;
                rr_ptr     <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                rsp_data_q <= '0;
                rsp_err_q  <= !sel_legal;
                if (sel_legal) begin
                    cfr_we   <= sel_wr;
                    cfr_re   <= !sel_wr;
                    cfr_addr <= sel_addr;
                    cfr_mask <= sel_mask;
                    cfr_din  <= sel_din;
                end
            end
            if (state == WAIT) begin
                rsp_data_q <= cfr_dout;
            end
            if (rsp_done) begin
                rsp_data_q <= '0;
                rsp_err_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cfr_access_arb.sv
// tb/tb_cfr_access_arb.sv - self-checking bench for cfr_access_arb
module tb_cfr_access_arb;
    import aimc_lib::*;

    localparam int N    = 2;
    localparam int AW   = CFR_ADDR_WIDTH;
    localparam int DW   = DATA_WIDTH;
    localparam int MW   = MASK_WIDTH;
    localparam int QCAP = 64;
    localparam int LEGAL [10] = '{0, 8, 9, 10, 11, 12, 13, 16, 24, 32};

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [MW-1:0] mask;
        logic [DW-1:0] din;
    } req_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cfr_access_arb_if #(.NUM_REQ(N)) bus ();

    logic          cfr_we;
    logic          cfr_re;
    logic [AW-1:0] cfr_addr;
    logic [MW-1:0] cfr_mask;
    logic [DW-1:0] cfr_din;
    logic [DW-1:0] cfr_dout = '0;

    cfr_access_arb #(.NUM_REQ(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_if   (bus),
        .cfr_we   (cfr_we),
        .cfr_re   (cfr_re),
        .cfr_addr (cfr_addr),
        .cfr_mask (cfr_mask),
        .cfr_din  (cfr_din),
        .cfr_dout (cfr_dout)
    );

    logic [DW-1:0] cfr_mem [0:63] = '{default: '0};
    logic [DW-1:0] cfr_w;

    // CFR register file stand-in: byte-masked writes, read data registered one cycle later.
    always @(posedge clk) begin
        if (cfr_we) begin
            cfr_w = cfr_mem[cfr_addr[5:0]];
            for (int b = 0; b < MW; b++) begin
                if (cfr_mask[b]) cfr_w[8*b +: 8] = cfr_din[8*b +: 8];
            end
            cfr_mem[cfr_addr[5:0]] <= cfr_w;
        end
        if (cfr_re) cfr_dout <= cfr_mem[cfr_addr[5:0]];
    end

    int strobe_cnt = 0;
    always @(negedge clk) begin
        if (cfr_we || cfr_re) strobe_cnt++;
    end

    int            n_assert = 0;
    int            n_fail   = 0;
    req_t          rq [N][QCAP];
    int            rq_n [N] = '{0, 0};
    int            rq_h [N] = '{0, 0};
    logic [DW-1:0] ref_mem [int];
    int            mptr = 0;
    int            glog [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_legal(input logic [AW-1:0] a);
        for (int i = 0; i < 10; i++) begin
            if (int'(a) == LEGAL[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
    endfunction

    function automatic void ref_write(input req_t t);
        logic [DW-1:0] w;
        w = ref_rd(t.addr);
        for (int b = 0; b < MW; b++) begin
            if (t.mask[b]) w[8*b +: 8] = t.din[8*b +: 8];
        end
        ref_mem[int'(t.addr)] = w;
    endfunction

    function automatic bit pend(input int r);
        return rq_h[r] < rq_n[r];
    endfunction

    function automatic void push(input int r, input logic wr, input int addr, input logic [MW-1:0] mask,
                                 input logic [DW-1:0] din);
        rq[r][rq_n[r]] = '{wr: wr, addr: AW'(addr), mask: mask, din: din};
        rq_n[r]++;
    endfunction

    function automatic req_t rand_req();
        req_t t;
        t.wr   = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) t.addr = AW'($urandom_range(0, 63));
        else                           t.addr = AW'(LEGAL[$urandom_range(0, 9)]);
        t.mask = MW'($urandom);
        t.din  = $urandom;
        return t;
    endfunction

    // Drives all queued requests, predicts grant order, strobe cycles and responses
    // from the arbitration/latency rules, and checks the DUT every cycle.
    // Entered and left 1 time unit after a rising edge.
    task automatic run(input int rmode, input int stall, input int max_cyc);
        bit            busy       = 0;
        bit            done       = 0;
        bit            cur_legal  = 0;
        int            own        = 0;
        int            due        = 0;
        int            acc        = 0;
        int            stall_left = stall;
        int            g;
        req_t          cur;
        req_t          t;
        logic [DW-1:0] exp_data   = '0;
        logic [N-1:0]  exp_ready;
        logic [N-1:0]  exp_rv;
        bit            exp_we;
        bit            exp_re;
        cur = '0;
        for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
            for (int r = 0; r < N; r++) begin
                bus.req_valid[r] = pend(r);
                if (pend(r)) begin
                    t = rq[r][rq_h[r]];
                    bus.req_wr[r]              = t.wr;
                    bus.req_addr[r*AW +: AW]   = t.addr;
                    bus.req_mask[r*MW +: MW]   = t.mask;
                    bus.req_din[r*DW +: DW]    = t.din;
                end
            end
            case (rmode)
                0:       bus.rsp_ready = '1;
                1:       bus.rsp_ready = N'($urandom);
                default: begin
                    bus.rsp_ready = '1;
                    if (busy && cyc >= due && stall_left > 0) begin
                        bus.rsp_ready[own] = 1'b0;
                        stall_left--;
                    end
                end
            endcase
            #1;
            exp_ready = '0;
            g         = -1;
            if (!busy) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (pend((mptr + k) % N)) g = (mptr + k) % N;
                end
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            chk("req_ready", bus.req_ready, exp_ready);
            exp_we = busy && cur_legal && cur.wr && (cyc == acc + 1);
            exp_re = busy && cur_legal && !cur.wr && (cyc == acc + 1);
            chk("cfr_we", cfr_we, exp_we);
            chk("cfr_re", cfr_re, exp_re);
            chk("cfr_addr", cfr_addr, (exp_we || exp_re) ? cur.addr : '0);
            if (exp_we) begin
                chk("cfr_mask", cfr_mask, cur.mask);
                chk("cfr_din", cfr_din, cur.din);
            end
            exp_rv = '0;
            if (busy && cyc >= due) exp_rv[own] = 1'b1;
            chk("rsp_valid", bus.rsp_valid, exp_rv);
            if (exp_rv != '0) begin
                chk("rsp_data", bus.rsp_data, exp_data);
                chk("rsp_err", bus.rsp_err, !cur_legal);
                if (bus.rsp_ready[own]) busy = 0;
            end
            if (g >= 0) begin
                cur       = rq[g][rq_h[g]];
                rq_h[g]++;
                glog.push_back(g);
                mptr      = (g + 1) % N;
                busy      = 1;
                own       = g;
                acc       = cyc;
                cur_legal = ref_legal(cur.addr);
                due       = cyc + (!cur_legal ? 1 : (cur.wr ? 2 : 3));
                exp_data  = '0;
                if (cur_legal && cur.wr)  ref_write(cur);
                if (cur_legal && !cur.wr) exp_data = ref_rd(cur.addr);
            end
            done = !busy && !pend(0) && !pend(1);
            @(posedge clk);
            #1;
        end
        chk("run_complete", done, 1'b1);
        bus.req_valid = '0;
        bus.rsp_ready = '1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_wr    = '0;
        bus.req_addr  = '0;
        bus.req_mask  = '0;
        bus.req_din   = '0;
        bus.rsp_ready = '1;

        // Reset state: all outputs low even with requests pending.
        @(posedge clk);
        #1;
        bus.req_valid = 2'b11;
        #1;
        chk("rst_req_ready", bus.req_ready, 2'b00);
        chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
        chk("rst_rsp_data", bus.rsp_data, '0);
        chk("rst_rsp_err", bus.rsp_err, 1'b0);
        chk("rst_cfr_strobes", {cfr_we, cfr_re}, 2'b00);
        chk("rst_cfr_buses", {cfr_addr, cfr_mask, cfr_din}, '0);
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single write, then readback through the CFR model and through the arbiter.
        push(0, 1'b1, 'h008, 4'hF, 32'd5);
        run(0, 0, 50);
        chk("tccd_cfr_word", cfr_mem[8], 32'd5);
        push(0, 1'b0, 'h008, 4'h0, 32'd0);
        run(0, 0, 50);

        // Single read of a preloaded word.
        push(0, 1'b1, 'h009, 4'hF, 32'hA5A5_A5A5);
        run(0, 0, 50);
        push(1, 1'b0, 'h009, 4'h0, 32'd0);
        run(0, 0, 50);

        // Fairness: both requesters hold four reads each.
        glog.delete();
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b0, LEGAL[i], 4'h0, 32'd0);
            push(1, 1'b0, LEGAL[9-i], 4'h0, 32'd0);
        end
        run(0, 0, 200);
        chk("fair_count", glog.size(), 8);
        for (int i = 0; i < 8 && i < glog.size(); i++) begin
            chk($sformatf("fair_order_%0d", i), glog[i], i % 2);
        end

        // Unmapped address: rejected without touching the CFR.
        s0 = strobe_cnt;
        push(0, 1'b1, 'h011, 4'hF, 32'hDEAD_BEEF);
        run(0, 0, 50);
        chk("unmapped_no_strobe", strobe_cnt, s0);

        // Response backpressure on requester 1 while requester 0 waits.
        push(1, 1'b0, 'h00C, 4'h0, 32'd0);
        push(0, 1'b1, 'h00C, 4'h3, 32'h1234_5678);
        run(2, 6, 100);

        // Randomized mix with random response readiness, including non-owner bits.
        for (int i = 0; i < 20; i++) begin
            req_t t0;
            req_t t1;
            t0 = rand_req();
            t1 = rand_req();
            push(0, t0.wr, int'(t0.addr), t0.mask, t0.din);
            push(1, t1.wr, int'(t1.addr), t1.mask, t1.din);
        end
        run(1, 0, 3000);

        // Reset in the WAIT cycle of a read drops it with no response and restarts at index 0.
        bus.req_valid                = 2'b01;
        bus.req_wr[0]                = 1'b0;
        bus.req_addr[0*AW +: AW]     = AW'('h00A);
        #1;
        chk("rstmid_accept", bus.req_ready, 2'b01);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        #1;
        chk("rstmid_cfr_re", cfr_re, 1'b1);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b10;
        rst_n         = 1'b0;
        #1;
        chk("rstmid_req_ready", bus.req_ready, 2'b00);
        chk("rstmid_rsp_valid", bus.rsp_valid, 2'b00);
        chk("rstmid_rsp", {bus.rsp_data, bus.rsp_err}, '0);
        chk("rstmid_cfr", {cfr_we, cfr_re, cfr_addr, cfr_mask, cfr_din}, '0);
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.req_valid = '0;
        mptr          = 0;
        s0            = strobe_cnt;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rstmid_no_rsp", bus.rsp_valid, 2'b00);
            @(posedge clk);
            #1;
        end
        chk("rstmid_no_strobe", strobe_cnt, s0);
        glog.delete();
        push(0, 1'b0, 'h010, 4'h0, 32'd0);
        push(1, 1'b0, 'h018, 4'h0, 32'd0);
        run(0, 0, 50);
        chk("rstmid_first_grant", (glog.size() > 0) ? glog[0] : -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
